// File: rtl/fft_bit_reverse_buffer.sv
// -----------------------------------------------------------------------------
// fft_bit_reverse_buffer
//
// Purpose:
//   This is a ping-pong frame buffer that sits after a radix-2 FFT butterfly
//   stage. It collects N = 2^LOG2_N samples in natural order into one bank.
//   While the next frame fills the other bank, it streams the finished bank
//   back out. The output is in bit-reversed order when the reorder feature is
//   enabled, and in natural order otherwise.
//
//   The output latency is 2 enabled cycles: one for the registered RAM read
//   and one for the output register. Back-to-back frames stream out with no
//   bubble between them.
//
// Configuration:
//   FFT_BITREV_REORDER_EN
//     - Defined:   the read address is bitrev(readCount).
//     - Undefined: the read address is readCount, giving a plain frame buffer
//       with identical timing.
//
// Parameters:
//   DATA_WIDTH  Sample width (default 33).
//   LOG2_N      log2 of the frame length (legal range 1..12).
//
// Ports:
//   clkIn     Clock. All state changes on the rising edge.
//   rstIn     Asynchronous, active-low reset. RAM contents are not cleared.
//   enIn      Global enable. When low, all state is frozen.
//   dataIn    Input sample, natural order.
//   validIn   Qualifier for dataIn.
//   dataOut   Reordered sample. Holds its value while validOut is low.
//   validOut  Qualifier for dataOut.
//   lastOut   High with the final sample of each output frame.
// -----------------------------------------------------------------------------
module fft_bit_reverse_buffer #(
  parameter int DATA_WIDTH = 33,
  parameter int LOG2_N     = 4
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  enIn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  lastOut
);

  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rdState_t;

  // Both banks live in one array. The bank select is the address MSB.
  logic [DATA_WIDTH-1:0] mem [0:2*N-1];

  logic [LOG2_N-1:0]     wrCntReg;
  logic                  wrBankReg;
  rdState_t              rdStateReg, rdStateNext;
  logic [LOG2_N-1:0]     rdCntReg, rdCntNext;
  logic                  rdBankReg, rdBankNext;
  logic [LOG2_N-1:0]     rdAddr;
  logic                  reading;
  logic [DATA_WIDTH-1:0] ramQReg;
  logic                  rdValidReg;
  logic                  rdLastReg;
  logic [DATA_WIDTH-1:0] dataOutReg;
  logic                  validOutReg;
  logic                  lastOutReg;

  logic accept;
  logic frameDone;

  assign accept    = enIn & validIn;
  // frameDone marks the edge that accepts the final sample of a frame.
  assign frameDone = accept & (wrCntReg == CNT_LAST);

`ifdef FFT_BITREV_REORDER_EN
  genvar gi;
  generate
    for (gi = 0; gi < LOG2_N; gi++) begin : gen_bitrev
      assign rdAddr[gi] = rdCntReg[LOG2_N-1-gi];
    end
  endgenerate
`else
  assign rdAddr = rdCntReg;
`endif

  // ---------------------------------------------------------------------------
  // Write side: the sample counter and the bank select.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      wrCntReg  <= '0;
      wrBankReg <= 1'b0;
    end else if (accept) begin
      wrCntReg <= wrCntReg + 1'b1;
      if (frameDone) begin
        wrBankReg <= ~wrBankReg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM with a registered read, and no reset so it maps to block RAM.
  // The reader always works on the opposite bank from the writer, so a
  // read and a write never target the same word in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkIn) begin
    if (accept) begin
      mem[{wrBankReg, wrCntReg}] <= dataIn;
    end
    if (enIn && reading) begin
      ramQReg <= mem[{rdBankReg, rdAddr}];
    end
  end

  // ---------------------------------------------------------------------------
  // Reader FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      rdStateReg <= IDLE;
      rdCntReg   <= '0;
      rdBankReg  <= 1'b0;
    end else if (enIn) begin
      rdStateReg <= rdStateNext;
      rdCntReg   <= rdCntNext;
      rdBankReg  <= rdBankNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Reader FSM: next-state logic.
  // A new frame can complete on the same edge that issues the last read of the
  // current frame. In that case the reader restarts at 0 on the new bank
  // without passing through IDLE, so the output stream has no bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdStateNext = rdStateReg;
    rdCntNext   = rdCntReg;
    rdBankNext  = rdBankReg;
    reading     = 1'b0;
    case (rdStateReg)
      IDLE: begin
        if (frameDone) begin
          rdStateNext = READ;
          rdCntNext   = '0;
          rdBankNext  = wrBankReg;
        end
      end
      READ: begin
        reading = 1'b1;
        if (rdCntReg == CNT_LAST) begin
          rdCntNext = '0;
          if (frameDone) begin
            rdBankNext = wrBankReg;
          end else begin
            rdStateNext = IDLE;
          end
        end else begin
          rdCntNext = rdCntReg + 1'b1;
        end
      end
      default: begin
        rdStateNext = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Valid/last pipeline aligned with the RAM read, then the output register.
  // dataOut only loads when a real sample arrives, so it holds otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      rdValidReg  <= 1'b0;
      rdLastReg   <= 1'b0;
      dataOutReg  <= '0;
      validOutReg <= 1'b0;
      lastOutReg  <= 1'b0;
    end else if (enIn) begin
      rdValidReg  <= reading;
      rdLastReg   <= reading && (rdCntReg == CNT_LAST);
      validOutReg <= rdValidReg;
      lastOutReg  <= rdLastReg;
      if (rdValidReg) begin
        dataOutReg <= ramQReg;
      end
    end
  end

  assign dataOut  = dataOutReg;
  assign validOut = validOutReg;
  assign lastOut  = lastOutReg;

endmodule
